// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: FSM state type and default parameters for count_monitor
package count_monitor_pkg;
  typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_SYNC, S_TRACK} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_LOSS_THRESH = 3;
  localparam int DEF_ERR_W = 4;
endpackage

// File: rtl/count_monitor_sat_counter.sv
// count_monitor_sat_counter: saturating event counter with synchronous clear
module count_monitor_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rstn || clr) q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks a free-running counter steps by +1; COUNT_MONITOR_STALL_OK_EN treats a held value as legal
module count_monitor import count_monitor_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TERMINAL = 2**WIDTH-1,
  parameter int SETTLE = DEF_SETTLE,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             step_err,
  output logic             terminal,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [7:0] settle_cnt, err_run;
  logic track, stall, bad, wrap, lost;
  assign track = state == S_TRACK;
`ifdef COUNT_MONITOR_STALL_OK_EN
  assign stall = count_in == prev;
`else
  assign stall = 1'b0;
`endif
  assign bad = track && count_in != prev + WIDTH'(1) && !stall;
  assign wrap = track && prev == WIDTH'(TERMINAL) && count_in == '0;
  assign lost = bad && err_run == 8'(LOSS_THRESH-1);
  assign locked = track;
  always_comb
    state_nxt = state == S_HOLD   ? (SETTLE == 0 ? S_SYNC : S_SETTLE) :
                state == S_SETTLE ? (settle_cnt == 8'(SETTLE-1) ? S_SYNC : S_SETTLE) :
                state == S_SYNC   ? S_TRACK :
                lost              ? S_SYNC : S_TRACK;
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= S_HOLD;
      prev <= '0;
      settle_cnt <= '0;
      err_run <= '0;
      step_err <= 1'b0;
      terminal <= 1'b0;
    end else begin
      state <= state_nxt;
      settle_cnt <= state == S_SETTLE ? settle_cnt + 8'd1 : '0;
      prev <= (state == S_SYNC || track) ? count_in : prev;
      // a legal stall leaves the run of consecutive errors untouched
      err_run <= (!track || lost) ? '0 : bad ? err_run + 8'd1 : stall ? err_run : '0;
      step_err <= bad;
      terminal <= track && count_in == WIDTH'(TERMINAL);
    end
  count_monitor_sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rstn(rstn), .inc(bad), .clr(clear), .q(err_count)
  );
  count_monitor_sat_counter #(.W(ERR_W)) u_wrap (
    .clk(clk), .rstn(rstn), .inc(wrap), .clr(clear), .q(wrap_count)
  );
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scoreboard bench for count_monitor; follows COUNT_MONITOR_STALL_OK_EN
module tb_count_monitor;
  logic clk = 1'b0, rstn = 1'b0, clear = 1'b0;
  logic [7:0] count_in = '0;
  logic locked, step_err, terminal;
  logic [3:0] err_count, wrap_count;
  typedef struct packed {logic l, s, t; logic [3:0] e, w;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0;
  string tag = "init";
`ifdef COUNT_MONITOR_STALL_OK_EN
  localparam bit STALL_OK = 1'b1;
`else
  localparam bit STALL_OK = 1'b0;
`endif
  always #5 clk = ~clk;
  count_monitor dut (
    .clk(clk), .rstn(rstn), .count_in(count_in), .clear(clear),
    .locked(locked), .step_err(step_err), .terminal(terminal),
    .err_count(err_count), .wrap_count(wrap_count)
  );
  task automatic cmp(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s [%s] t=%0t: got %0d, want %0d", n, tag, $time, act, req);
    end
  endtask
  // Each entry holds the outputs expected right after the edge following its drive.
  task automatic drv(input int r, input int c, input int clr, input int l, input int s,
                     input int t, input int e, input int w);
    exp_t x;
    @(negedge clk);
    rstn = 1'(r);
    count_in = 8'(c);
    clear = 1'(clr);
    x = '{1'(l), 1'(s), 1'(t), 4'(e), 4'(w)};
    sb.push_back(x);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        cmp("locked", int'(locked), int'(x.l));
        cmp("step_err", int'(step_err), int'(x.s));
        cmp("terminal", int'(terminal), int'(x.t));
        cmp("err_count", int'(err_count), int'(x.e));
        cmp("wrap_count", int'(wrap_count), int'(x.w));
      end
    end
  end
  initial begin
    int e;
    tag = "reset";
    repeat (5) drv(0, 0, 0, 0, 0, 0, 0, 0);
    tag = "release";
    for (int i = 0; i < 4; i++) drv(1, i, 0, int'(i == 3), 0, 0, 0, 0);
    tag = "full_run";
    for (int i = 4; i < 268; i++) drv(1, i % 256, 0, 1, 0, int'(i == 255), 0, int'(i >= 256));
    tag = "glitch";
    drv(1, 40, 0, 1, 1, 0, 1, 1);
    drv(1, 41, 0, 1, 0, 0, 1, 1);
    drv(1, 42, 0, 1, 0, 0, 1, 1);
    tag = "loss";
    drv(1, 43, 1, 1, 0, 0, 0, 0);
    drv(1, 5, 0, 1, 1, 0, 1, 0);
    drv(1, 9, 0, 1, 1, 0, 2, 0);
    drv(1, 2, 0, 0, 1, 0, 3, 0);
    drv(1, 7, 0, 1, 0, 0, 3, 0);
    drv(1, 8, 0, 1, 0, 0, 3, 0);
    tag = "saturate";
    e = 3;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 != 3 && e < 15) e++;
      drv(1, (i % 2 != 0) ? 100 : 200, 0, int'(i % 4 != 2), int'(i % 4 != 3), 0, e, 0);
    end
    tag = "clear_err";
    drv(1, 7, 1, 1, 1, 0, 0, 0);
    drv(1, 8, 0, 1, 0, 0, 0, 0);
    tag = "clear_wrap";
    drv(1, 255, 0, 1, 1, 1, 1, 0);
    drv(1, 0, 1, 1, 0, 0, 0, 0);
    drv(1, 1, 0, 1, 0, 0, 0, 0);
    tag = "stall";
    drv(1, 49, 1, 1, 1, 0, 0, 0);
    drv(1, 50, 0, 1, 0, 0, 0, 0);
    drv(1, 50, 0, 1, int'(!STALL_OK), 0, STALL_OK ? 0 : 1, 0);
    drv(1, 50, 0, 1, int'(!STALL_OK), 0, STALL_OK ? 0 : 2, 0);
    drv(1, 51, 0, 1, 0, 0, STALL_OK ? 0 : 2, 0);
    tag = "mid_reset";
    drv(0, 52, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, i, 0, int'(i >= 3), 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    tag = "drain";
    cmp("scoreboard_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
